// File: rtl/sorter_request_scheduler_pkg.sv
// sorter_request_scheduler_pkg: shared defaults for the sorter request scheduler
package sorter_request_scheduler_pkg;
    localparam int DEF_NUM_REQUESTER = 4;
    localparam int DEF_SINGLE_WAY_WIDTH_IN_BITS = 4;
    localparam int DEF_NUM_WAY = 16;
    localparam int DEF_SORTER_LATENCY = 4;
    localparam int DEF_RESULT_FIFO_DEPTH = 8;
    localparam int SORTER_ID_WIDTH = $clog2(DEF_NUM_REQUESTER);

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sorter_request_scheduler_result_fifo.sv
// sorter_result_fifo: synchronous FIFO whose head entry lives in the output register
module sorter_result_fifo
    import sorter_request_scheduler_pkg::*;
#(
    parameter int WIDTH = 66,
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             write_valid_in,
    input  logic [WIDTH-1:0] write_data_in,
    input  logic             read_ready_in,
    output logic             head_valid_out,
    output logic [WIDTH-1:0] head_data_out,
    output logic             full_out,
    output logic             empty_out
);
    localparam int PTR_W = ptr_width(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0] count;
    logic pop, load, mem_empty, mem_write;
    assign pop = head_valid_out & read_ready_in;
    assign load = ~head_valid_out | pop;
    // count includes the head register, so the backing store is empty when only the head is held
    assign mem_empty = count == {{PTR_W{1'b0}}, head_valid_out};
    assign mem_write = write_valid_in & ~(load & mem_empty);
    assign full_out = count == (PTR_W+1)'(DEPTH);
    assign empty_out = count == '0;
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            head_valid_out <= 1'b0;
            head_data_out <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(mem_write);
            rd_ptr <= rd_ptr + PTR_W'(load & ~mem_empty);
            count <= count + (PTR_W+1)'(write_valid_in) - (PTR_W+1)'(pop);
            if (load)
                head_valid_out <= ~mem_empty | write_valid_in;
            if (load && (!mem_empty || write_valid_in))
                head_data_out <= mem_empty ? write_data_in : mem[rd_ptr];
        end
    end
    always_ff @(posedge clk_in)
        if (mem_write)
            mem[wr_ptr] <= write_data_in;
endmodule

// File: rtl/sorter_request_scheduler.sv
// sorter_request_scheduler: round-robin front end sharing one pipelined sorter among clients,
// returning tagged results in issue order through a credit-protected FIFO
module sorter_request_scheduler
    import sorter_request_scheduler_pkg::*;
#(
    parameter int NUM_REQUESTER = DEF_NUM_REQUESTER,
    parameter int SINGLE_WAY_WIDTH_IN_BITS = DEF_SINGLE_WAY_WIDTH_IN_BITS,
    parameter int NUM_WAY = DEF_NUM_WAY,
    parameter int SORTER_LATENCY = DEF_SORTER_LATENCY,
    parameter int RESULT_FIFO_DEPTH = DEF_RESULT_FIFO_DEPTH,
    localparam int DATA_W = SINGLE_WAY_WIDTH_IN_BITS * NUM_WAY,
    localparam int ID_W = $clog2(NUM_REQUESTER)
) (
    input  logic                            clk_in,
    input  logic                            reset_in,
    input  logic [NUM_REQUESTER-1:0]        request_valid_in,
    input  logic [NUM_REQUESTER*DATA_W-1:0] request_flatted_in,
    output logic [NUM_REQUESTER-1:0]        request_ready_out,
    output logic [DATA_W-1:0]               sorter_pre_sort_flatted_out,
    input  logic [DATA_W-1:0]               sorter_post_sort_flatted_in,
    output logic                            result_valid_out,
    output logic [ID_W-1:0]                 result_id_out,
    output logic [DATA_W-1:0]               result_flatted_out,
    input  logic                            result_ready_in,
    output logic                            busy_out
);
    localparam int CNT_W = $clog2(RESULT_FIFO_DEPTH) + 1;
    logic [ID_W-1:0] rr_ptr, grant, idx;
    logic found, issue, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] outstanding;
    logic [SORTER_LATENCY-1:0] tag_valid;
    logic [ID_W-1:0] tag_id [SORTER_LATENCY];
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx = '0;
        for (int k = 0; k < NUM_REQUESTER; k++) begin
            idx = rr_ptr + ID_W'(k);
            if (!found && request_valid_in[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end
    // credit covers both in-flight tags and FIFO entries, so the capture never meets a full FIFO
    assign issue = reset_in && found && (outstanding < CNT_W'(RESULT_FIFO_DEPTH));
    assign request_ready_out = issue ? NUM_REQUESTER'(1) << grant : '0;
    assign pop = result_valid_out & result_ready_in;
    assign busy_out = outstanding != '0;
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            rr_ptr <= '0;
            outstanding <= '0;
            sorter_pre_sort_flatted_out <= '0;
            tag_valid <= '0;
            for (int i = 0; i < SORTER_LATENCY; i++)
                tag_id[i] <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= grant + 1'b1;
                sorter_pre_sort_flatted_out <= request_flatted_in[grant*DATA_W +: DATA_W];
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(pop);
            tag_valid[0] <= issue;
            tag_id[0] <= grant;
            for (int i = 1; i < SORTER_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end
    sorter_result_fifo #(.WIDTH(ID_W + DATA_W), .DEPTH(RESULT_FIFO_DEPTH)) u_fifo (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .write_valid_in (tag_valid[SORTER_LATENCY-1]),
        .write_data_in  ({tag_id[SORTER_LATENCY-1], sorter_post_sort_flatted_in}),
        .read_ready_in  (result_ready_in),
        .head_valid_out (result_valid_out),
        .head_data_out  ({result_id_out, result_flatted_out}),
        .full_out       (fifo_full),
        .empty_out      (fifo_empty)
    );
    assert property (@(posedge clk_in) disable iff (!reset_in) !(fifo_full && tag_valid[SORTER_LATENCY-1]));
    assert property (@(posedge clk_in) disable iff (!reset_in) fifo_empty |-> !result_valid_out);
endmodule

// File: tb/tb_sorter_request_scheduler.sv
// tb_sorter_request_scheduler: directed checks of arbitration, credit, ordering and reset
module tb_sorter_request_scheduler;
    localparam int N = 4;
    localparam int DW = 64;
    localparam int L = 4;
    logic clk_in = 1'b0;
    logic reset_in = 1'b0;
    logic [N-1:0] request_valid_in = '0;
    logic [N-1:0] request_ready_out;
    logic [N*DW-1:0] request_flatted_in = '0;
    logic [DW-1:0] pre, post, result_flatted_out;
    logic result_valid_out, busy_out;
    logic result_ready_in = 1'b0;
    logic [1:0] result_id_out;
    logic [DW-1:0] sp [L-1];
    int checks = 0;
    int errors = 0;
    int hs, pops;
    logic stale;

    always #5 clk_in = ~clk_in;

    sorter_request_scheduler dut (
        .clk_in                      (clk_in),
        .reset_in                    (reset_in),
        .request_valid_in            (request_valid_in),
        .request_flatted_in          (request_flatted_in),
        .request_ready_out           (request_ready_out),
        .sorter_pre_sort_flatted_out (pre),
        .sorter_post_sort_flatted_in (post),
        .result_valid_out            (result_valid_out),
        .result_id_out               (result_id_out),
        .result_flatted_out          (result_flatted_out),
        .result_ready_in             (result_ready_in),
        .busy_out                    (busy_out)
    );

    function automatic logic [63:0] sort16(input logic [63:0] v);
        logic [3:0] a [16];
        logic [3:0] t;
        logic [63:0] r;
        for (int i = 0; i < 16; i++) a[i] = v[i*4 +: 4];
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                end
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = a[i];
        return r;
    endfunction

    // sorter model: input register inside the DUT plus three more stages here
    always @(posedge clk_in) begin
        sp[0] <= sort16(pre);
        sp[1] <= sp[0];
        sp[2] <= sp[1];
    end
    assign post = sp[2];

    function automatic logic [63:0] rep(input logic [3:0] n);
        return {16{n}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic set_vec(input int i, input logic [63:0] v);
        request_flatted_in[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        tick();
        reset_in = 1'b0;
        request_valid_in = '0;
        result_ready_in = 1'b0;
        tick();
        reset_in = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        #1;
        chk("rst_ready", request_ready_out, 0);
        chk("rst_valid", result_valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_pre", pre, 0);
        chk("rst_data", result_flatted_out, 0);
        reset_in = 1'b1;

        // single request from client 2
        tick();
        set_vec(2, 64'h0123456789abcdef);
        request_valid_in = 4'b0100;
        #1;
        chk("t1_ready", request_ready_out, 4'b0100);
        tick();
        request_valid_in = '0;
        #1;
        chk("t1_pre_sort", pre, 64'h0123456789abcdef);
        chk("t1_busy", busy_out, 1);
        repeat (3) tick();
        #1;
        chk("t1_not_early", result_valid_out, 0);
        tick();
        #1;
        chk("t1_valid", result_valid_out, 1);
        chk("t1_id", result_id_out, 2);
        chk("t1_data", result_flatted_out, 64'hfedcba9876543210);
        result_ready_in = 1'b1;
        tick();
        #1;
        chk("t1_popped", result_valid_out, 0);
        chk("t1_idle", busy_out, 0);

        // all clients streaming, consumer always ready
        do_reset();
        result_ready_in = 1'b1;
        for (int i = 0; i < N; i++) set_vec(i, rep(4'(i + 5)));
        for (int k = 0; k < 13; k++) begin
            tick();
            request_valid_in = (k < 8) ? 4'hf : 4'h0;
            #1;
            if (k < 8) chk("t2_grant", request_ready_out, 64'(4'b1 << (k % 4)));
            if (k >= 5) begin
                chk("t2_valid", result_valid_out, 1);
                chk("t2_id", result_id_out, 64'((k - 5) % 4));
                chk("t2_data", result_flatted_out, rep(4'((k - 5) % 4 + 5)));
            end
        end
        tick();
        #1;
        chk("t2_drained", busy_out, 0);

        // consumer stalled: credit limits client 0 to eight requests
        result_ready_in = 1'b0;
        set_vec(0, 64'h0123456789abcdef);
        hs = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            request_valid_in = 4'b0001;
            #1;
            if ((request_ready_out & request_valid_in) != 0) hs++;
        end
        chk("t3_handshakes", hs, 8);
        chk("t3_no_credit", request_ready_out, 0);
        tick();
        result_ready_in = 1'b1;
        #1;
        chk("t3_pop_cycle", request_ready_out, 0);
        pops = 1;
        tick();
        result_ready_in = 1'b0;
        #1;
        chk("t3_reissue", request_ready_out, 4'b0001);
        tick();
        #1;
        chk("t3_full_again", request_ready_out, 0);
        for (int k = 0; k < 40; k++) begin
            tick();
            request_valid_in = '0;
            result_ready_in = 1'b1;
            #1;
            if (!busy_out) break;
            if (result_valid_out) pops++;
        end
        chk("t3_drain_idle", busy_out, 0);
        chk("t3_pops", pops, 9);

        // duplicates from client 3, then client 1, with a stalled head
        result_ready_in = 1'b0;
        set_vec(3, 64'h2e0c86a4e0c2a864);
        set_vec(1, 64'h87b4acfa03f54892);
        tick();
        request_valid_in = 4'b1000;
        #1;
        chk("t5_grant3", request_ready_out, 4'b1000);
        tick();
        request_valid_in = 4'b0010;
        #1;
        chk("t5_grant1", request_ready_out, 4'b0010);
        tick();
        request_valid_in = '0;
        repeat (3) tick();
        #1;
        chk("t5_valid", result_valid_out, 1);
        chk("t5_id3", result_id_out, 3);
        chk("t5_data3", result_flatted_out, 64'heeccaa8866442200);
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            chk("t4_hold_valid", result_valid_out, 1);
            chk("t4_hold_id", result_id_out, 3);
            chk("t4_hold_data", result_flatted_out, 64'heeccaa8866442200);
        end
        tick();
        result_ready_in = 1'b1;
        #1;
        chk("t4_pop_id", result_id_out, 3);
        tick();
        #1;
        chk("t5_valid1", result_valid_out, 1);
        chk("t5_id1", result_id_out, 1);
        chk("t5_data1", result_flatted_out, 64'hffcbaa9887544320);
        tick();
        #1;
        chk("t5_empty", result_valid_out, 0);
        chk("t5_idle", busy_out, 0);

        // reset with three requests in flight
        result_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) set_vec(i, rep(4'(i + 1)));
        hs = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            request_valid_in = 4'b0111;
            #1;
            if ((request_ready_out & request_valid_in) != 0) hs++;
        end
        chk("t6_inflight", hs, 3);
        tick();
        reset_in = 1'b0;
        #1;
        chk("t6_rst_ready", request_ready_out, 0);
        chk("t6_rst_busy", busy_out, 0);
        chk("t6_rst_pre", pre, 0);
        chk("t6_rst_valid", result_valid_out, 0);
        chk("t6_rst_id", result_id_out, 0);
        tick();
        reset_in = 1'b1;
        request_valid_in = '0;
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            #1;
            stale = stale | result_valid_out | busy_out;
        end
        chk("t6_no_stale", stale, 0);
        set_vec(1, 64'h0123456789abcdef);
        tick();
        request_valid_in = 4'b0010;
        #1;
        chk("t6_grant", request_ready_out, 4'b0010);
        tick();
        request_valid_in = '0;
        repeat (3) tick();
        #1;
        chk("t6_not_early", result_valid_out, 0);
        tick();
        #1;
        chk("t6_valid", result_valid_out, 1);
        chk("t6_id", result_id_out, 1);
        chk("t6_data", result_flatted_out, 64'hfedcba9876543210);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
